// File: rtl/mem_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_line_ctrl
// Description : Multi-cycle main-memory model behind the data cache. It serves
//               whole-line refills (read) and dirty-line writebacks (write)
//               over a req/gnt handshake. Each access has a fixed first-access
//               latency, then moves one word per cycle.
//
// Ports
//   clk           in   1              pipeline clock
//   rst           in   1              synchronous active-high reset
//   rd_req        in   1              line refill request
//   rd_line_addr  in   LA_W           line address for refill
//   rd_line       out  32*LINE_SIZE   refill data, word i at [32i+31:32i]
//   wr_req        in   1              line writeback request (wins over rd_req)
//   wr_line_addr  in   LA_W           line address for writeback
//   wr_line       in   32*LINE_SIZE   writeback data, same packing
//   gnt           out  1              one-cycle completion pulse
//   busy          out  1              high while a transaction is in flight
//   rd_cnt        out  32             completed reads (wrapping)
//   wr_cnt        out  32             completed writes (wrapping)
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_line_ctrl #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int MEM_ADDR_LEN  = 12,
    parameter int LATENCY       = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   rd_req,
    input  logic [MEM_ADDR_LEN-LINE_ADDR_LEN-1:0]  rd_line_addr,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]       rd_line,
    input  logic                                   wr_req,
    input  logic [MEM_ADDR_LEN-LINE_ADDR_LEN-1:0]  wr_line_addr,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]       wr_line,
    output logic                                   gnt,
    output logic                                   busy,
    output logic [31:0]                            rd_cnt,
    output logic [31:0]                            wr_cnt
);

    localparam int C_LINE_SIZE = 2**LINE_ADDR_LEN;
    localparam int C_LINE_W    = 32*C_LINE_SIZE;
    localparam int C_LA_W      = MEM_ADDR_LEN-LINE_ADDR_LEN;
    localparam int C_MEM_DEPTH = 2**MEM_ADDR_LEN;
    // LATENCY-1 is the largest value the wait counter ever holds.
    localparam int C_CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [C_CNT_W-1:0]       C_WAIT_LOAD = C_CNT_W'(LATENCY-1);
    localparam logic [LINE_ADDR_LEN-1:0] C_LAST_IDX  = LINE_ADDR_LEN'(C_LINE_SIZE-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                     r_state;
    logic                       r_op_wr;
    logic [C_LA_W-1:0]          r_line_addr;
    logic [C_LINE_W-1:0]        r_wr_line;
    logic [C_CNT_W-1:0]         r_wait_cnt;
    logic [LINE_ADDR_LEN-1:0]   r_idx;
    logic [C_LINE_W-1:0]        r_rd_line;
    logic                       r_gnt;
    logic                       r_busy;
    logic [31:0]                r_rd_cnt;
    logic [31:0]                r_wr_cnt;

    // Backing store; intentionally not reset.
    logic [31:0]                r_mem [0:C_MEM_DEPTH-1];

    logic [MEM_ADDR_LEN-1:0]    w_mem_addr;
    logic [31:0]                w_wr_word;
    logic                       w_mem_we;
    logic [LINE_ADDR_LEN+4:0]   w_word_lsb;

    // Line address and word index together cover the full store exactly.
    assign w_mem_addr = {r_line_addr, r_idx};
    assign w_word_lsb = {r_idx, 5'b00000};

    always_comb begin
        w_wr_word = r_wr_line[w_word_lsb +: 32];
    end

    // A reset arriving in the same cycle as a write beat suppresses that beat;
    // beats committed earlier stay in the array.
    assign w_mem_we = (r_state == S_XFER) && r_op_wr && !rst;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op_wr     <= 1'b0;
            r_line_addr <= '0;
            r_wr_line   <= '0;
            r_wait_cnt  <= '0;
            r_idx       <= '0;
            r_rd_line   <= '0;
            r_gnt       <= 1'b0;
            r_busy      <= 1'b0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_gnt <= 1'b0;
                    if (wr_req || rd_req) begin
                        // Writeback has priority; a losing read is not queued.
                        r_op_wr     <= wr_req;
                        r_line_addr <= wr_req ? wr_line_addr : rd_line_addr;
                        if (wr_req) begin
                            r_wr_line <= wr_line;
                        end
                        r_wait_cnt  <= C_WAIT_LOAD;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_idx   <= '0;
                        r_state <= S_XFER;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end

                S_XFER: begin
                    if (!r_op_wr) begin
                        r_rd_line[w_word_lsb +: 32] <= r_mem[w_mem_addr];
                    end
                    if (r_idx == C_LAST_IDX) begin
                        // Grant and counter become visible together in DONE.
                        r_gnt <= 1'b1;
                        if (r_op_wr) begin
                            r_wr_cnt <= r_wr_cnt + 32'd1;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + 32'd1;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                S_DONE: begin
                    // IDLE always lasts at least one cycle after a grant.
                    r_gnt   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_gnt   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_line = r_rd_line;
    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign rd_cnt  = r_rd_cnt;
    assign wr_cnt  = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_line_ctrl
// Description : Directed self-checking bench for mem_line_ctrl with default
//               parameters (8-word lines, 4096-word store, latency 4).
//               Inputs are driven and outputs sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_line_ctrl;

    localparam int C_LA_W   = 9;
    localparam int C_LINE_W = 256;

    logic                clk;
    logic                rst;
    logic                rd_req;
    logic [C_LA_W-1:0]   rd_line_addr;
    logic [C_LINE_W-1:0] rd_line;
    logic                wr_req;
    logic [C_LA_W-1:0]   wr_line_addr;
    logic [C_LINE_W-1:0] wr_line;
    logic                gnt;
    logic                busy;
    logic [31:0]         rd_cnt;
    logic [31:0]         wr_cnt;

    int tests;
    int fails;
    int exp_rd;
    int exp_wr;

    mem_line_ctrl #(
        .LINE_ADDR_LEN (3),
        .MEM_ADDR_LEN  (12),
        .LATENCY       (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_req       (rd_req),
        .rd_line_addr (rd_line_addr),
        .rd_line      (rd_line),
        .wr_req       (wr_req),
        .wr_line_addr (wr_line_addr),
        .wr_line      (wr_line),
        .gnt          (gnt),
        .busy         (busy),
        .rd_cnt       (rd_cnt),
        .wr_cnt       (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [C_LINE_W-1:0] make_line(input logic [31:0] base);
        logic [C_LINE_W-1:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = base + 32'(i);
        end
        return l;
    endfunction

    // Counts falling edges after the accepting rising edge until gnt is seen;
    // returns -1 if gnt never shows within the budget.
    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt && n < 60);
        if (!gnt) n = -1;
    endtask

    // Presents one request at a falling edge, waits for gnt, then drops it.
    task automatic run_txn(input bit is_wr, input logic [C_LA_W-1:0] addr,
                           input logic [C_LINE_W-1:0] data, output int lat);
        if (is_wr) begin
            wr_req = 1'b1; wr_line_addr = addr; wr_line = data;
        end else begin
            rd_req = 1'b1; rd_line_addr = addr;
        end
        wait_gnt(lat);
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++; if (gnt !== 1'b0) begin fails++; $display("FAIL reset_gnt got %0b want 0", gnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
        tests++; if (rd_cnt !== 32'd0) begin fails++; $display("FAIL reset_rd_cnt got %0d want 0", rd_cnt); end
        tests++; if (wr_cnt !== 32'd0) begin fails++; $display("FAIL reset_wr_cnt got %0d want 0", wr_cnt); end
        tests++; if (rd_line !== '0) begin fails++; $display("FAIL reset_rd_line got %h want 0", rd_line); end
    endtask

    // Abort a write to line 12 while it is transferring word 3.
    task automatic test_reset_xfer;
        int  lat;
        bit  saw_gnt;
        wr_req = 1'b1; wr_line_addr = 9'd12; wr_line = make_line(32'hC00);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (gnt) saw_gnt = 1'b1;
        end
        // Falling edge 8 lies in the word-3 beat; reset is sampled at its end.
        rst = 1'b1; wr_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %0b want 0", busy); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt) saw_gnt = 1'b1;
        end
        tests++; if (saw_gnt !== 1'b0) begin fails++; $display("FAIL abort_no_gnt got %0b want 0", saw_gnt); end
        tests++; if (wr_cnt !== 32'd0) begin fails++; $display("FAIL abort_wr_cnt got %0d want 0", wr_cnt); end
        // Words 0..2 were committed before the abort.
        run_txn(1'b0, 9'd12, '0, lat);
        exp_rd++;
        tests++; if (rd_line[95:0] !== {32'hC02, 32'hC01, 32'hC00})
            begin fails++; $display("FAIL abort_kept_words got %h want 00000c0200000c0100000c00", rd_line[95:0]); end
        tests++; if (rd_cnt !== 32'(exp_rd)) begin fails++; $display("FAIL abort_rd_cnt got %0d want %0d", rd_cnt, exp_rd); end
        @(negedge clk);
    endtask

    task automatic test_write_read;
        int lat;
        run_txn(1'b1, 9'd5, make_line(32'h100), lat);
        exp_wr++;
        tests++; if (lat != 13) begin fails++; $display("FAIL wr_latency got %0d want 13", lat); end
        tests++; if (wr_cnt !== 32'(exp_wr)) begin fails++; $display("FAIL wr_cnt got %0d want %0d", wr_cnt, exp_wr); end
        @(negedge clk);
        tests++; if (gnt !== 1'b0) begin fails++; $display("FAIL gnt_pulse got %0b want 0", gnt); end
        run_txn(1'b0, 9'd5, '0, lat);
        exp_rd++;
        tests++; if (lat != 13) begin fails++; $display("FAIL rd_latency got %0d want 13", lat); end
        tests++; if (rd_line !== make_line(32'h100)) begin fails++; $display("FAIL rd_line5 got %h want %h", rd_line, make_line(32'h100)); end
        tests++; if (rd_cnt !== 32'(exp_rd)) begin fails++; $display("FAIL rd_cnt got %0d want %0d", rd_cnt, exp_rd); end
        @(negedge clk);
    endtask

    task automatic test_priority;
        int lat;
        rd_req = 1'b1; rd_line_addr = 9'd5;
        wr_req = 1'b1; wr_line_addr = 9'd7; wr_line = make_line(32'h700);
        wait_gnt(lat);
        rd_req = 1'b0; wr_req = 1'b0;
        exp_wr++;
        tests++; if (wr_cnt !== 32'(exp_wr)) begin fails++; $display("FAIL prio_wr_cnt got %0d want %0d", wr_cnt, exp_wr); end
        tests++; if (rd_cnt !== 32'(exp_rd)) begin fails++; $display("FAIL prio_rd_cnt got %0d want %0d", rd_cnt, exp_rd); end
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL prio_not_queued got busy %0b want 0", busy); end
        run_txn(1'b0, 9'd5, '0, lat);
        exp_rd++;
        tests++; if (rd_line !== make_line(32'h100)) begin fails++; $display("FAIL prio_rd5 got %h want %h", rd_line, make_line(32'h100)); end
        @(negedge clk);
        run_txn(1'b0, 9'd7, '0, lat);
        exp_rd++;
        tests++; if (rd_line !== make_line(32'h700)) begin fails++; $display("FAIL prio_rd7 got %h want %h", rd_line, make_line(32'h700)); end
        tests++; if (rd_cnt !== 32'(exp_rd)) begin fails++; $display("FAIL prio_rd_cnt2 got %0d want %0d", rd_cnt, exp_rd); end
        @(negedge clk);
    endtask

    task automatic test_wait_change;
        int lat;
        wr_req = 1'b1; wr_line_addr = 9'd9; wr_line = make_line(32'h900);
        repeat (2) @(negedge clk);
        // Now in WAIT: alter every request input.
        wr_line_addr = 9'd10; wr_line = make_line(32'hDEAD0000);
        wait_gnt(lat);
        wr_req = 1'b0;
        exp_wr++;
        tests++; if (rd_line !== make_line(32'h700)) begin fails++; $display("FAIL wr_keeps_rd_line got %h want %h", rd_line, make_line(32'h700)); end
        @(negedge clk);
        run_txn(1'b0, 9'd9, '0, lat);
        exp_rd++;
        tests++; if (rd_line !== make_line(32'h900)) begin fails++; $display("FAIL captured_data got %h want %h", rd_line, make_line(32'h900)); end
        tests++; if (wr_cnt !== 32'(exp_wr)) begin fails++; $display("FAIL change_wr_cnt got %0d want %0d", wr_cnt, exp_wr); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat;
        rd_req = 1'b1; rd_line_addr = 9'd5;
        wait_gnt(lat);
        tests++; if (lat != 13) begin fails++; $display("FAIL b2b_first_latency got %0d want 13", lat); end
        // Request stays high across gnt; next accept follows one IDLE cycle.
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap got busy %0b want 0", busy); end
        wait_gnt(lat);
        rd_req = 1'b0;
        exp_rd += 2;
        tests++; if (lat != 13) begin fails++; $display("FAIL b2b_gnt_spacing got %0d want 14", lat + 1); end
        tests++; if (rd_cnt !== 32'(exp_rd)) begin fails++; $display("FAIL b2b_rd_cnt got %0d want %0d", rd_cnt, exp_rd); end
        tests++; if (rd_line !== make_line(32'h100)) begin fails++; $display("FAIL b2b_rd_line got %h want %h", rd_line, make_line(32'h100)); end
        @(negedge clk);
    endtask

    initial begin
        tests = 0; fails = 0; exp_rd = 0; exp_wr = 0;
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        rd_line_addr = '0; wr_line_addr = '0; wr_line = '0;
        @(negedge clk);
        test_reset;
        test_reset_xfer;
        test_write_read;
        test_priority;
        test_wait_change;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
